// File: rtl/ser_pkg.sv
// Shared constants and state encoding for the serial front end and the
// pattern-detector benches that reuse its defaults.
package ser_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam int unsigned DEF_WIDTH    = 8;
   localparam logic        DEF_IDLE_BIT = 1'b0;

   // Width of a length field able to hold 0..w.
   function automatic int unsigned len_bits(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out signal bundle of the serializer.
interface bit_serializer_if #(
   parameter int unsigned WIDTH = ser_pkg::DEF_WIDTH
);
   localparam int unsigned LW = ser_pkg::len_bits(WIDTH);

   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic [LW-1:0]    s_len;
   logic             ser_out;
   logic             ser_valid;
   logic             last;

   modport master (
      output s_valid, s_data, s_len,
      input  s_ready, ser_out, ser_valid, last
   );

   modport slave (
      input  s_valid, s_data, s_len,
      output s_ready, ser_out, ser_valid, last
   );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: takes a word over valid/ready and shifts it
// out MSB first, one bit per clock, chaining words without a bubble.
module bit_serializer
   import ser_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter logic        IDLE_BIT = DEF_IDLE_BIT
) (
   input  logic             clk,
   input  logic             rst,
   bit_serializer_if.slave  bus
);
   localparam int unsigned LW = len_bits(WIDTH);

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
   logic [LW-1:0]    r_cnt,   w_cnt_nxt;
   logic [LW-1:0]    w_len_eff;
   logic             w_last;
   logic             w_ready;
   logic             w_accept;

   assign w_last   = (r_state == ST_SHIFT) && (r_cnt == '0);
   // Ready depends only on state (and reset), never on s_valid.
   assign w_ready  = !rst && ((r_state == ST_IDLE) || w_last);
   assign w_accept = bus.s_valid && w_ready;

   // Zero and oversize lengths both mean a full word.
   always_comb begin
      w_len_eff = bus.s_len;
      if ((bus.s_len == '0) || (bus.s_len > LW'(WIDTH)))
         w_len_eff = LW'(WIDTH);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shreg_nxt = r_shreg;
      w_cnt_nxt   = r_cnt;
      if (w_accept) begin
         w_state_nxt = ST_SHIFT;
         w_shreg_nxt = bus.s_data;
         w_cnt_nxt   = w_len_eff - LW'(1);
      end else begin
         case (r_state)
            ST_SHIFT: begin
               if (r_cnt == '0) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
                  w_cnt_nxt   = r_cnt - LW'(1);
               end
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_shreg <= w_shreg_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign bus.s_ready   = w_ready;
   assign bus.ser_valid = (r_state == ST_SHIFT);
   assign bus.ser_out   = (r_state == ST_SHIFT) ? r_shreg[WIDTH-1] : IDLE_BIT;
   assign bus.last      = w_last;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: queue-based bit-stream model,
// a table of single words, hand sequences and randomized traffic.
module tb_bit_serializer;
   import ser_pkg::*;

   localparam int unsigned W  = 8;
   localparam int unsigned LW = len_bits(W);

   logic clk = 1'b0;
   logic rst = 1'b1;

   bit_serializer_if #(.WIDTH(W)) bus();

   bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int unsigned errors = 0;
   int unsigned checks = 0;

   // Model: pending {bit, is_last} of the word currently on the wire.
   logic [1:0] q[$];
   logic smp_out, smp_valid, smp_last, smp_ready, last_acc;

   typedef struct {
      logic [W-1:0]  data;
      logic [LW-1:0] len;
      int unsigned   exp_n;
      logic [W-1:0]  exp_bits;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_word(input logic [W-1:0] d, input logic [LW-1:0] len);
      int unsigned n;
      n = ((len == 0) || (len > W)) ? W : int'(len);
      for (int unsigned i = 0; i < n; i++)
         q.push_back({d[W-1-i], (i == n - 1)});
   endtask

   // One clock: compare outputs to the model mid-cycle, then advance the model.
   task automatic cycle();
      logic acc;
      @(negedge clk);
      smp_out   = bus.ser_out;
      smp_valid = bus.ser_valid;
      smp_last  = bus.last;
      smp_ready = bus.s_ready;
      chk("ser_valid", smp_valid, (q.size() > 0));
      chk("ser_out",   smp_out,   (q.size() > 0) ? q[0][1] : 1'b0);
      chk("last",      smp_last,  (q.size() > 0) ? q[0][0] : 1'b0);
      chk("s_ready",   smp_ready, (!rst && (q.size() <= 1)));
      acc = bus.s_valid && !rst && (q.size() <= 1);
      @(posedge clk);
      if (rst) begin
         q.delete();
      end else begin
         if (q.size() > 0) void'(q.pop_front());
         if (acc) push_word(bus.s_data, bus.s_len);
      end
      last_acc = acc;
      #1;
   endtask

   initial begin
      logic [15:0]  col16;
      logic [W-1:0] col;
      int unsigned  n, first_idx, last_idx, rdy_cnt;

      vecs[0] = '{8'hB0, 4'd4,  4, 8'hB0};
      vecs[1] = '{8'hA5, 4'd0,  8, 8'hA5};
      vecs[2] = '{8'h80, 4'd1,  1, 8'h80};
      vecs[3] = '{8'hFF, 4'd15, 8, 8'hFF};
      vecs[4] = '{8'h3C, 4'd9,  8, 8'h3C};
      vecs[5] = '{8'hC3, 4'd2,  2, 8'hC0};
      vecs[6] = '{8'h5A, 4'd7,  7, 8'h5A};

      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_len   = '0;
      last_acc    = 1'b0;
      @(posedge clk);
      #1;

      // Reset held, then idle.
      cycle();
      cycle();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      chk("idle_ready", smp_ready, 1'b1);
      chk("idle_out",   smp_out,   1'b0);

      // Single words from the table.
      foreach (vecs[v]) begin
         bus.s_valid = 1'b1;
         bus.s_data  = vecs[v].data;
         bus.s_len   = vecs[v].len;
         cycle();
         chk("tbl_accept", last_acc, 1'b1);
         bus.s_valid = 1'b0;
         bus.s_data  = ~vecs[v].data;
         bus.s_len   = 4'd3;
         col = '0; n = 0; first_idx = 0; last_idx = 0;
         for (int unsigned c = 1; c <= 12; c++) begin
            cycle();
            if (smp_valid) begin
               if (n < W) col[W-1-n] = smp_out;
               n++;
               if (first_idx == 0) first_idx = c;
               if (smp_last) last_idx = c;
            end
         end
         chk("tbl_nbits",   n,         vecs[v].exp_n);
         chk("tbl_bits",    col,       vecs[v].exp_bits);
         chk("tbl_latency", first_idx, 1);
         chk("tbl_lastpos", last_idx,  vecs[v].exp_n);
      end

      // A5 then 3C with valid held: 16 gapless bits.
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hA5;
      bus.s_len   = '0;
      cycle();
      bus.s_data  = 8'h3C;
      col16 = '0; n = 0; rdy_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         cycle();
         if (smp_valid) begin
            col16 = {col16[14:0], smp_out};
            n++;
         end
         if (smp_ready) rdy_cnt++;
         if (last_acc) bus.s_valid = 1'b0;
      end
      chk("b2b_bits",  col16,   16'hA53C);
      chk("b2b_valid", n,       16);
      chk("b2b_ready", rdy_cnt, 2);
      cycle();

      // Two single-bit words back to back.
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h80;
      bus.s_len   = 4'd1;
      cycle();
      bus.s_data  = 8'h00;
      cycle();
      chk("len1_a_out",  smp_out,  1'b1);
      chk("len1_a_last", smp_last, 1'b1);
      bus.s_valid = 1'b0;
      cycle();
      chk("len1_b_out",   smp_out,   1'b0);
      chk("len1_b_valid", smp_valid, 1'b1);
      chk("len1_b_last",  smp_last,  1'b1);
      cycle();

      // Reset on the third bit of a full word.
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hFF;
      bus.s_len   = 4'd8;
      cycle();
      bus.s_valid = 1'b0;
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      chk("rst_bit3", smp_out, 1'b1);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("rst_abort_valid", smp_valid, 1'b0);
         chk("rst_abort_out",   smp_out,   1'b0);
      end

      // Input changes while busy are ignored.
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hA5;
      bus.s_len   = '0;
      cycle();
      bus.s_valid = 1'b0;
      col = '0; n = 0;
      for (int i = 0; i < 9; i++) begin
         bus.s_data = W'($urandom);
         bus.s_len  = LW'($urandom_range(0, 15));
         cycle();
         if (smp_valid) begin
            if (n < W) col[W-1-n] = smp_out;
            n++;
         end
      end
      chk("busy_ignore_bits", col, 8'hA5);
      chk("busy_ignore_n",    n,   8);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         rst         = ($urandom_range(0, 49) == 0);
         bus.s_valid = ($urandom_range(0, 3) != 0);
         bus.s_data  = W'($urandom);
         bus.s_len   = LW'($urandom_range(0, 15));
         cycle();
      end
      rst = 1'b0;
      bus.s_valid = 1'b0;
      for (int i = 0; i < 10; i++) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
